// File: rtl/seq_multiplier_8x8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
//   MUL_WIDTH   : default operand width (product is 2*MUL_WIDTH bits)
//   mul_state_e : FSM state encodings. 2'd3 is unused and decodes to IDLE.
package seq_multiplier_8x8_pkg;

    localparam int MUL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier_8x8_adder.sv
// Partial-sum adder for the shift-and-add multiplier.
//   a_i, b_i : ADD_W-bit unsigned addends
//   sum_o    : low ADD_W bits of a_i + b_i
//   cout_o   : carry out of the top bit
module seq_multiplier_8x8_adder #(
    parameter int ADD_W = 8
) (
    input  logic [ADD_W-1:0] a_i,
    input  logic [ADD_W-1:0] b_i,
    output logic [ADD_W-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_multiplier_8x8.sv
// Sequential unsigned shift-and-add multiplier. One iteration per clock,
// WIDTH iterations per product, one-cycle done_o pulse with the result.
//   mul_clk_i    : clock, rising edge
//   mul_nreset_i : asynchronous active-low reset
//   start_i      : request; sampled in IDLE and DONE only
//   a_i, b_i     : unsigned operands, captured with start_i
//   busy_o       : high while iterating (RUN)
//   done_o       : one-cycle pulse, product_o holds a new result
//   product_o    : last completed product, held between results
module seq_multiplier_8x8
    import seq_multiplier_8x8_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 mul_clk_i,
    input  logic                 mul_nreset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_e       state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] partial;  // upper half of the running product
    logic [WIDTH-1:0] mplier;   // lower half: unconsumed multiplier bits shift out, product bits shift in
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             last_iter;

    assign addend    = mplier[0] ? mcand : '0;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    seq_multiplier_8x8_adder #(
        .ADD_W (WIDTH)
    ) u_adder (
        .a_i    (partial),
        .b_i    (addend),
        .sum_o  (sum),
        .cout_o (carry)
    );

    // State register
    always_ff @(posedge mul_clk_i or negedge mul_nreset_i) begin
        if (!mul_nreset_i) state <= ST_IDLE;
        else               state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = start_i   ? ST_RUN  : ST_IDLE;
            ST_RUN:  state_nxt = last_iter ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = start_i   ? ST_RUN  : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            ST_RUN:  busy_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath. A start in DONE restarts immediately, giving back-to-back
    // operation; a start in RUN falls through and is dropped.
    always_ff @(posedge mul_clk_i or negedge mul_nreset_i) begin
        if (!mul_nreset_i) begin
            mcand     <= '0;
            partial   <= '0;
            mplier    <= '0;
            count     <= '0;
            product_o <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        mcand   <= a_i;
                        mplier  <= b_i;
                        partial <= '0;
                        count   <= '0;
                    end
                end
                ST_RUN: begin
                    // {carry, sum, mplier} >> 1
                    partial <= {carry, sum[WIDTH-1:1]};
                    mplier  <= {sum[0], mplier[WIDTH-1:1]};
                    count   <= count + CNT_W'(1);
                    if (last_iter)
                        product_o <= {carry, sum, mplier[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule
